// File: rtl/aes_pkg.sv
// Shared AES definitions for the column-serial cipher: GF(2^8) helpers, S-box, MixColumn,
// key-schedule sizing and FSM encodings.
package aes_pkg;

  localparam int unsigned AES_NWORDS    = 44;
  localparam logic [5:0]  AES_LAST_ADDR = 6'd43;

  typedef logic [1:0] fsm_t;
  localparam fsm_t FSM_IDLE   = 2'd0;
  localparam fsm_t FSM_KSTART = 2'd1;
  localparam fsm_t FSM_RUN    = 2'd2;
  localparam fsm_t FSM_DONE   = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mixcolumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] m0, m1, m2, m3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {m0, m1, m2, m3};
  endfunction

endpackage

// File: rtl/aes_col_round.sv
// One AES column through SubBytes, optional MixColumn and AddRoundKey (purely combinational).
module aes_col_round
  import aes_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [31:0] rk,
  input  logic        mix_en,
  output logic [31:0] col
);

  logic [31:0] sub;

  assign sub = {sbox(b0), sbox(b1), sbox(b2), sbox(b3)};
  assign col = (mix_en ? mixcolumn(sub) : sub) ^ rk;

endmodule

// File: rtl/aes_cipher_col32.sv
// AES-128 encrypt, one 32-bit column per cycle, fed word-by-word by an external key expansion.
// Optional key-word sequencing check enabled by defining AES_KS_CHECK_EN.
module aes_cipher_col32
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         ks_start,
  output logic [127:0] ks_key,
  output logic         ks_next,
  input  logic [31:0]  ks_word,
  input  logic [5:0]   ks_addr,
  input  logic         ks_ready,
  output logic         ks_err
);

  fsm_t         fsm_q, fsm_d;
  logic [31:0]  state_q [4];
  logic [31:0]  nxt_q [3];
  logic [5:0]   word_cnt_q;
  logic [127:0] out_ct_q;
  logic [127:0] ks_key_q;

  logic [1:0]   col;
  logic [3:0]   rnd;
  logic         consume;
  logic         accept;
  logic         last_word;
  logic [7:0]   sr_b [4];
  logic [31:0]  rnd_col;

  assign col       = word_cnt_q[1:0];
  assign rnd       = word_cnt_q[5:2];
  assign consume   = (fsm_q == FSM_RUN) && ks_ready;
  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt_q == AES_LAST_ADDR);
  assign out_ct    = out_ct_q;
  assign ks_key    = ks_key_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      FSM_IDLE:   if (in_valid) fsm_d = FSM_KSTART;
      FSM_KSTART: fsm_d = FSM_RUN;
      FSM_RUN:    if (consume && last_word) fsm_d = FSM_DONE;
      FSM_DONE:   if (out_ready) fsm_d = FSM_IDLE;
      default:    fsm_d = FSM_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ks_start  = 1'b0;
    ks_next   = 1'b0;
    unique case (fsm_q)
      FSM_IDLE:   in_ready = 1'b1;
      FSM_KSTART: ks_start = 1'b1;
      FSM_RUN:    ks_next  = ks_ready && (word_cnt_q < AES_LAST_ADDR);
      FSM_DONE:   out_valid = 1'b1;
      default:    ;
    endcase
  end

  // ShiftRows gather: row i of output column c comes from committed column (c+i) mod 4.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sr_b[i] = state_q[col + 2'(i)][31-8*i -: 8];
    end
  end

  aes_col_round u_col_round (
    .b0     (sr_b[0]),
    .b1     (sr_b[1]),
    .b2     (sr_b[2]),
    .b3     (sr_b[3]),
    .rk     (ks_word),
    .mix_en (rnd != 4'd10),
    .col    (rnd_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) state_q[c] <= '0;
      for (int c = 0; c < 3; c++) nxt_q[c] <= '0;
      word_cnt_q <= '0;
      out_ct_q   <= '0;
      ks_key_q   <= '0;
    end else begin
      if (accept) begin
        for (int c = 0; c < 4; c++) state_q[c] <= in_pt[127-32*c -: 32];
        ks_key_q <= in_key;
      end

      if (fsm_q == FSM_KSTART) begin
        word_cnt_q <= '0;
      end else if (ks_next) begin
        word_cnt_q <= word_cnt_q + 6'd1;
      end

      if (consume) begin
        if (rnd == 4'd0) begin
          state_q[col] <= state_q[col] ^ ks_word;
        end else begin
          // Columns 0..2 wait in nxt_q so later columns still read the previous round.
          case (col)
            2'd0: nxt_q[0] <= rnd_col;
            2'd1: nxt_q[1] <= rnd_col;
            2'd2: nxt_q[2] <= rnd_col;
            default: begin
              state_q[0] <= nxt_q[0];
              state_q[1] <= nxt_q[1];
              state_q[2] <= nxt_q[2];
              state_q[3] <= rnd_col;
            end
          endcase
        end
        if (last_word) out_ct_q <= {nxt_q[0], nxt_q[1], nxt_q[2], rnd_col};
      end
    end
  end

`ifdef AES_KS_CHECK_EN
  logic ks_err_q;
  logic first_run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_err_q    <= 1'b0;
      first_run_q <= 1'b0;
    end else begin
      first_run_q <= (fsm_q == FSM_KSTART);
      if (accept) begin
        ks_err_q <= 1'b0;
      end else if ((first_run_q && !ks_ready) || (consume && (ks_addr != word_cnt_q))) begin
        ks_err_q <= 1'b1;
      end
    end
  end

  assign ks_err = ks_err_q;
`else
  logic unused_ks_addr;
  assign unused_ks_addr = ^ks_addr;
  assign ks_err         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_cipher_col32.sv
// Bench for aes_cipher_col32: behavioural key-expansion partner, FIPS-197 vectors, random
// blocks against a byte-level AES model, scoreboard checked by an independent monitor.
module tb_aes_cipher_col32;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_KS_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_pt, in_key, out_ct, ks_key;
  logic         ks_start, ks_next, ks_ready, ks_err;
  logic [31:0]  ks_word;
  logic [5:0]   ks_addr;

  logic [7:0]    sbox_tb [256];
  logic [1407:0] kx_sched;
  logic [5:0]    kx_addr;
  logic          kx_valid;
  logic          stall, corrupt;

  logic [127:0] exp_q [$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int got_cnt = 0;
  int n_sent = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_col32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .ks_start  (ks_start),
    .ks_key    (ks_key),
    .ks_next   (ks_next),
    .ks_word   (ks_word),
    .ks_addr   (ks_addr),
    .ks_ready  (ks_ready),
    .ks_err    (ks_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the generator-3 log walk: p runs over 3^n, q over 3^-n.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tb[p] = x ^ 8'h63;
    end
    sbox_tb[0] = 8'h63;
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tb[t[31:24]] ^ rc, sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] ks;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] rk;
    logic [127:0] r;
    ks = expand(key);
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) t[4*c+rw] = sbox_tb[s[4*((c+rw)%4)+rw]];
        for (int c = 0; c < 4; c++) begin
          if (rd < 10) begin
            s[4*c+0] = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
            s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
            s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
            s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
          end else begin
            for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*c+rw];
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        rk = ks[1407-32*(4*rd+c) -: 32];
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = s[4*c+rw] ^ rk[31-8*rw -: 8];
      end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  // ---------------- key expansion partner ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_addr  <= '0;
      kx_valid <= 1'b0;
      kx_sched <= '0;
    end else if (ks_start) begin
      kx_sched <= expand(ks_key);
      kx_addr  <= '0;
      kx_valid <= 1'b1;
    end else if (ks_next) begin
      kx_addr <= kx_addr + 6'd1;
    end
  end

  assign ks_word  = kx_sched[1407-32*kx_addr -: 32];
  assign ks_ready = kx_valid && !stall;
  assign ks_addr  = (corrupt && kx_addr == 6'd10) ? 6'd63 : kx_addr;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL ct_unexpected: got %h, expected no output", out_ct);
      end else begin
        check("ct", out_ct, exp_q.pop_front());
      end
      got_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_out_ct"}, out_ct, 128'd0);
    check({tag, "_ks_start"}, 128'(ks_start), 128'd0);
    check({tag, "_ks_next"}, 128'(ks_next), 128'd0);
    check({tag, "_ks_key"}, ks_key, 128'd0);
    check({tag, "_ks_err"}, 128'(ks_err), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    int n;
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) timeout("send");
    exp_q.push_back(exp);
    n_sent++;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_pt    = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input bit rand_bp);
    int n;
    n = 0;
    while (got_cnt < n_sent && n < 2000) begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    if (got_cnt < n_sent) timeout("wait_out");
  endtask

  task automatic wait_addr(input logic [5:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kx_addr != a && n < 200);
    if (kx_addr != a) timeout("wait_addr");
  endtask

  initial begin
    logic [127:0] pt, key, hold_addr;
    int n;
    build_sbox();
    in_valid = 1'b0; in_pt = '0; in_key = '0; out_ready = 1'b1;
    stall = 1'b0; corrupt = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1
    send(C1_PT, C1_KEY, C1_CT);
    check("ks_key_latched", ks_key, C1_KEY);
    wait_out(1'b0);
    check("ks_err_clean", 128'(ks_err), 128'd0);

    // FIPS-197 B with latency measurement
    send(C2_PT, C2_KEY, C2_CT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("latency", 128'(cyc - acc_cyc), 128'd45);
    wait_out(1'b0);

    // Backpressure, then back-to-back blocks
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    repeat (20) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_ct}, {1'b1, 1'b0, C1_CT});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_out(1'b0);
    send(C1_PT, C1_KEY, C1_CT);
    send(C2_PT, C2_KEY, C2_CT);
    wait_out(1'b0);

    // Key-schedule stall in round 4
    send(C2_PT, C2_KEY, C2_CT);
    wait_addr(6'd17);
    @(posedge clk);
    #1;
    stall     = 1'b1;
    hold_addr = 128'(kx_addr);
    repeat (5) begin
      @(negedge clk);
      check("stall_ks_next", 128'(ks_next), 128'd0);
      check("stall_addr", 128'(kx_addr), hold_addr);
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    wait_out(1'b0);

    // Reset in the middle of a block
    send(C1_PT, C1_KEY, C1_CT);
    wait_addr(6'd20);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_q.delete();
    n_sent = got_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(C2_PT, C2_KEY, C2_CT);
    wait_out(1'b0);

    // Corrupted key-word index
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    corrupt = 1'b1;
    send(pt, key, aes_ref(pt, key));
    wait_out(1'b0);
    check("ks_err_set", 128'(ks_err), 128'(EXP_ERR));
    corrupt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ks_err_sticky", 128'(ks_err), 128'(EXP_ERR));
    send(C1_PT, C1_KEY, C1_CT);
    check("ks_err_cleared", 128'(ks_err), 128'd0);
    wait_out(1'b0);
    check("ks_err_after_clean", 128'(ks_err), 128'd0);

    // Random blocks with random output backpressure
    for (int b = 0; b < 6; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key, aes_ref(pt, key));
      wait_out(1'b1);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
